// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receive path: FSM states, width helpers
// and the legality check applied to every receiver parameter set.
package spart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned BIT_IDX_W     = $clog2(DATA_BITS_MAX);

  function automatic int unsigned tick_width(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

  // One extra pointer bit separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit rx_params_legal(
    input int unsigned data_bits,
    input int unsigned oversample,
    input int unsigned fifo_depth,
    input int unsigned parity_en,
    input int unsigned parity_odd,
    input int unsigned stop_bits
  );
    return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
           (oversample >= 4) && ((oversample % 2) == 0) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           (parity_en <= 1) && (parity_odd <= 1) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Synchronous receive FIFO; push and pop may coincide at any occupancy,
// and a push into a full FIFO only lands when a pop frees the slot.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [ptr_width(DEPTH)-1:0]  count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count;
  logic             do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty_o  = (count == '0);
    full_o   = (count == PW'(DEPTH));
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_o  = count;
    data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/spart_rx_core.sv
// SPART receive engine: synchroniser, oversampling tick counter, 2-of-3 bit
// voting, frame FSM, sticky error flags and the receive FIFO.
module spart_rx_core
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_en,
  input  logic                          rxd,
  input  logic                          iocs,
  input  logic                          iorw,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_rda,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  if (!rx_params_legal(DATA_BITS, OVERSAMPLE, FIFO_DEPTH, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_param_check
    $error("spart_rx_core: illegal parameter set");
  end

  localparam int unsigned TICK_W = tick_width(OVERSAMPLE);
  localparam logic [TICK_W-1:0]    TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0]    TICK_MID_M = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]    TICK_MID   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0]    TICK_MID_P = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST   = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic                 STOP_LAST  = (STOP_BITS == 2);
  localparam logic                 ODD_SENSE  = (PARITY_ODD != 0);
  localparam rx_state_t            AFTER_DATA = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;

  logic                 rxd_meta_q, rxd_s_q;
  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           vote_q, vote_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 push_q, push_d;
  logic [DATA_BITS-1:0] push_data_q, push_data_d;
  logic                 push_bad_q, push_bad_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_evt, bit_val, sample_now;
  logic                 pop_req, fifo_empty, fifo_full;

  assign pop_req    = iocs & iorw;
  assign sample_now = (tick_q == TICK_MID_P);
  assign bit_val    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s_q) | (vote_q[1] & rxd_s_q);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    vote_d      = vote_q;
    par_bad_d   = par_bad_q;
    stop_idx_d  = stop_idx_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_bad_d  = push_bad_q;
    frame_evt   = 1'b0;
    if (baud_en) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      if (tick_q == TICK_MID_M) vote_d[0] = rxd_s_q;
      if (tick_q == TICK_MID)   vote_d[1] = rxd_s_q;
      unique case (state_q)
        RX_IDLE: begin
          // Tick 0 is the first tick after the falling edge is seen.
          tick_d = '0;
          if (!rxd_s_q) state_d = RX_START;
        end
        RX_START: begin
          if (sample_now) begin
            if (!bit_val) begin
              state_d   = RX_DATA;
              idx_d     = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (sample_now) begin
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              stop_idx_d = 1'b0;
              state_d    = AFTER_DATA;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (sample_now) begin
            par_bad_d  = (^shift_q) ^ bit_val ^ ODD_SENSE;
            stop_idx_d = 1'b0;
            state_d    = RX_STOP;
          end
        end
        RX_STOP: begin
          if (sample_now) begin
            if (!bit_val) begin
              frame_evt = 1'b1;
              state_d   = RX_BREAK;
            end else if (stop_idx_q == STOP_LAST) begin
              push_d      = 1'b1;
              push_data_d = shift_q;
              push_bad_d  = par_bad_q;
              state_d     = RX_IDLE;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        RX_BREAK: begin
          tick_d = '0;
          if (rxd_s_q) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Flags set on the event cycle; set wins over a coincident clear.
  always_comb begin
    frame_err_d  = frame_evt | (frame_err_q & ~err_clr);
    parity_err_d = (push_q & push_bad_q) | (parity_err_q & ~err_clr);
    overrun_d    = (push_q & fifo_full & ~pop_req) | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      state_q      <= RX_IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      vote_q       <= '1;
      par_bad_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_bad_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd;
      rxd_s_q      <= rxd_meta_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      vote_q       <= vote_d;
      par_bad_q    <= par_bad_d;
      stop_idx_q   <= stop_idx_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      push_bad_q   <= push_bad_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  spart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (pop_req),
    .data_o  (rx_data),
    .count_o (rx_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rx_rda     = ~fifo_empty;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spart_rx_core.sv
// Directed bench for spart_rx_core: three receiver configurations share one
// clock and reset; a per-instance scoreboard queue holds expected words.
module tb_spart_rx_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 8N1 defaults, 1: 8 data + even parity, 2: 7 data + 2 stop.
  logic       rxd_a = 1'b1, iocs_a = 1'b0, iorw_a = 1'b0, clr_a = 1'b0;
  logic       rxd_p = 1'b1, iocs_p = 1'b0, iorw_p = 1'b0, clr_p = 1'b0;
  logic       rxd_s = 1'b1, iocs_s = 1'b0, iorw_s = 1'b0, clr_s = 1'b0;
  logic [7:0] data_a, data_p;
  logic [6:0] data_s;
  logic [2:0] cnt_a, cnt_p, cnt_s;
  logic       rda_a, rda_p, rda_s;
  logic       perr_a, perr_p, perr_s, ferr_a, ferr_p, ferr_s, ovr_a, ovr_p, ovr_s;

  spart_rx_core u_dut_a (
    .clk(clk), .rst_n(rst_n), .baud_en(1'b1), .rxd(rxd_a), .iocs(iocs_a), .iorw(iorw_a),
    .err_clr(clr_a), .rx_data(data_a), .rx_rda(rda_a), .rx_count(cnt_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  spart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .baud_en(1'b1), .rxd(rxd_p), .iocs(iocs_p), .iorw(iorw_p),
    .err_clr(clr_p), .rx_data(data_p), .rx_rda(rda_p), .rx_count(cnt_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p)
  );

  spart_rx_core #(.DATA_BITS(7), .STOP_BITS(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .baud_en(1'b1), .rxd(rxd_s), .iocs(iocs_s), .iorw(iorw_s),
    .err_clr(clr_s), .rx_data(data_s), .rx_rda(rda_s), .rx_count(cnt_s),
    .parity_err(perr_s), .frame_err(ferr_s), .overrun(ovr_s)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] q_a[$], q_p[$], q_s[$];
  logic exp_ovr[3] = '{1'b0, 1'b0, 1'b0};
  logic exp_perr[3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rxd(input int w, input logic v);
    case (w)
      0: rxd_a = v;
      1: rxd_p = v;
      default: rxd_s = v;
    endcase
  endtask

  function automatic logic [8:0] get_data(input int w);
    case (w)
      0: return {1'b0, data_a};
      1: return {1'b0, data_p};
      default: return {2'b00, data_s};
    endcase
  endfunction

  function automatic logic [2:0] get_cnt(input int w);
    case (w)
      0: return cnt_a;
      1: return cnt_p;
      default: return cnt_s;
    endcase
  endfunction

  function automatic logic [3:0] get_stat(input int w);
    case (w)
      0: return {rda_a, perr_a, ferr_a, ovr_a};
      1: return {rda_p, perr_p, ferr_p, ovr_p};
      default: return {rda_s, perr_s, ferr_s, ovr_s};
    endcase
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0: return q_a.size();
      1: return q_p.size();
      default: return q_s.size();
    endcase
  endfunction

  task automatic model_push(input int w, input logic [8:0] d);
    if (qsize(w) >= 4) exp_ovr[w] = 1'b1;
    else case (w)
      0: q_a.push_back(d);
      1: q_p.push_back(d);
      default: q_s.push_back(d);
    endcase
  endtask

  task automatic model_pop(input int w, output logic [8:0] d);
    d = 9'h1FF;
    case (w)
      0: if (q_a.size() > 0) d = q_a.pop_front();
      1: if (q_p.size() > 0) d = q_p.pop_front();
      default: if (q_s.size() > 0) d = q_s.pop_front();
    endcase
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input int nbits,
                            input bit pen, input bit pbit, input int nstop);
    set_rxd(w, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      set_rxd(w, d[i]);
      repeat (16) @(negedge clk);
    end
    if (pen) begin
      set_rxd(w, pbit);
      repeat (16) @(negedge clk);
      if ((^d[7:0]) ^ pbit) exp_perr[w] = 1'b1;
    end
    for (int i = 0; i < nstop; i++) begin
      set_rxd(w, 1'b1);
      repeat (16) @(negedge clk);
    end
    model_push(w, d);
  endtask

  task automatic wait_count(input int w, input string tag, input logic [2:0] exp);
    for (int i = 0; i < 40 && get_cnt(w) != exp; i++) @(negedge clk);
    check(tag, 16'(get_cnt(w)), 16'(exp));
  endtask

  task automatic check_flags(input int w, input string tag);
    logic [3:0] st;
    st = get_stat(w);
    check({tag, "_perr"}, 16'(st[2]), 16'(exp_perr[w]));
    check({tag, "_ovr"},  16'(st[0]), 16'(exp_ovr[w]));
  endtask

  task automatic read_word(input int w, input string tag);
    logic [8:0] exp;
    logic [3:0] st;
    st = get_stat(w);
    check({tag, "_rda"}, 16'(st[3]), 16'd1);
    model_pop(w, exp);
    check(tag, 16'(get_data(w)), 16'(exp));
    case (w)
      0: begin iocs_a = 1'b1; iorw_a = 1'b1; end
      1: begin iocs_p = 1'b1; iorw_p = 1'b1; end
      default: begin iocs_s = 1'b1; iorw_s = 1'b1; end
    endcase
    @(negedge clk);
    iocs_a = 1'b0; iorw_a = 1'b0;
    iocs_p = 1'b0; iorw_p = 1'b0;
    iocs_s = 1'b0; iorw_s = 1'b0;
  endtask

  task automatic pulse_clr(input int w);
    case (w)
      0: clr_a = 1'b1;
      1: clr_p = 1'b1;
      default: clr_s = 1'b1;
    endcase
    exp_perr[w] = 1'b0;
    exp_ovr[w]  = 1'b0;
    @(negedge clk);
    clr_a = 1'b0; clr_p = 1'b0; clr_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input int w, input string tag);
    check({tag, "_stat"}, 16'(get_stat(w)), 16'd0);
    check({tag, "_cnt"},  16'(get_cnt(w)), 16'd0);
    check({tag, "_data"}, 16'(get_data(w)), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check_all_zero(0, "rst_a");
    check_all_zero(1, "rst_p");
    check_all_zero(2, "rst_s");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 1: single 8N1 frame
    send_frame(0, 9'h0A5, 8, 0, 0, 1);
    wait_count(0, "t1_cnt", 3'd1);
    check("t1_ferr", 16'(ferr_a), 16'd0);
    check_flags(0, "t1");
    iorw_a = 1'b1;                       // read strobe without chip select
    @(negedge clk);
    iorw_a = 1'b0;
    check("t1_nocs_cnt", 16'(cnt_a), 16'd1);
    read_word(0, "t1_data");
    check("t1_rda_after", 16'(rda_a), 16'd0);

    // 2: glitch rejection, then parity frames
    rxd_p = 1'b0;
    repeat (3) @(negedge clk);
    rxd_p = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_glitch_cnt", 16'(cnt_p), 16'd0);
    check("t2_glitch_stat", 16'(get_stat(1)), 16'd0);
    send_frame(1, 9'h00F, 8, 1, 1'b1, 1);
    wait_count(1, "t2_cnt", 3'd1);
    check_flags(1, "t2_bad");
    read_word(1, "t2_data");
    pulse_clr(1);
    check_flags(1, "t2_clr");
    send_frame(1, 9'h007, 8, 1, 1'b1, 1);
    wait_count(1, "t2_good_cnt", 3'd1);
    check_flags(1, "t2_good");
    read_word(1, "t2_good_data");

    // 3: overrun with five back-to-back frames, no reads
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 8, 0, 0, 1);
    wait_count(0, "t3_cnt", 3'd4);
    check_flags(0, "t3");
    for (int i = 0; i < 4; i++) read_word(0, "t3_data");
    check("t3_rda_after", 16'(rda_a), 16'd0);
    pulse_clr(0);
    check_flags(0, "t3_clr");

    // 4: break line
    rxd_a = 1'b0;
    repeat (240) @(negedge clk);
    check("t4_ferr_set", 16'(ferr_a), 16'd1);
    pulse_clr(0);
    repeat (238) @(negedge clk);
    check("t4_ferr_once", 16'(ferr_a), 16'd0);
    check("t4_cnt_hold", 16'(cnt_a), 16'd0);
    rxd_a = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(0, 9'h03C, 8, 0, 0, 1);
    wait_count(0, "t4_cnt", 3'd1);
    check("t4_ferr_after", 16'(ferr_a), 16'd0);
    read_word(0, "t4_data");

    // 5: full FIFO with a read coinciding with the fifth push
    send_frame(2, 9'h011, 7, 0, 0, 2);
    send_frame(2, 9'h022, 7, 0, 0, 2);
    send_frame(2, 9'h033, 7, 0, 0, 2);
    send_frame(2, 9'h044, 7, 0, 0, 2);
    wait_count(2, "t5_fill", 3'd4);
    fork
      send_frame(2, 9'h055, 7, 0, 0, 2);
      begin
        repeat (157) @(negedge clk);
        read_word(2, "t5_conc_read");
      end
    join
    repeat (2) @(negedge clk);
    check("t5_cnt", 16'(cnt_s), 16'd4);
    check_flags(2, "t5");
    for (int i = 0; i < 4; i++) read_word(2, "t5_drain");
    check("t5_ferr", 16'(ferr_s), 16'd0);

    // 6: reset mid-frame (parity_err left set on instance 1 beforehand)
    send_frame(1, 9'h001, 8, 1, 1'b0, 1);
    wait_count(1, "t6_pre_cnt", 3'd1);
    check_flags(1, "t6_pre");
    send_frame(0, 9'h077, 8, 0, 0, 1);
    wait_count(0, "t6_pre_a", 3'd1);
    rxd_a = 1'b0;
    repeat (16) @(negedge clk);
    rxd_a = 1'b1;
    repeat (32) @(negedge clk);
    rxd_a = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero(0, "t6_rst_a");
    check_all_zero(1, "t6_rst_p");
    q_a.delete(); q_p.delete(); q_s.delete();
    exp_perr = '{1'b0, 1'b0, 1'b0};
    exp_ovr  = '{1'b0, 1'b0, 1'b0};
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(0, 9'h0C3, 8, 0, 0, 1);
    wait_count(0, "t6_cnt", 3'd1);
    check_flags(0, "t6");
    read_word(0, "t6_data");
    check("t6_rda_after", 16'(rda_a), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
